// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle for fifo_sync_param: write side, read side, status flags and error flags.
// The master modport is the traffic source and sink; the slave modport is the FIFO itself.
interface fifo_sync_param_if #(
  parameter int DSIZE = 12,
  parameter int ASIZE = 3
);
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic             wfull_almost;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rempty_almost;
  logic [ASIZE:0]   count;
  logic             clr_err;
  logic             overflow;
  logic             underflow;

  modport master (
    output wdata, winc, rinc, clr_err,
    input  wfull, wfull_almost, rdata, rempty, rempty_almost, count, overflow, underflow
  );

  modport slave (
    input  wdata, winc, rinc, clr_err,
    output wfull, wfull_almost, rdata, rempty, rempty_almost, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with programmable almost flags, occupancy and sticky error flags.
// Define FIFO_FWFT_EN for show-ahead read data; otherwise read data is registered on each pop.
module fifo_sync_param #(
  parameter int DSIZE     = 12,
  parameter int ASIZE     = 3,
  parameter int AFULL_TH  = (1 << ASIZE) - 1,
  parameter int AEMPTY_TH = 1
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_param_if.slave bus
);
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] CNT_FULL = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] CNT_AF   = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] CNT_AE   = (ASIZE+1)'(AEMPTY_TH);
  localparam logic [ASIZE:0] CNT_ONE  = (ASIZE+1)'(1);
  localparam logic [ASIZE-1:0] PTR_ONE = ASIZE'(1);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [ASIZE-1:0] waddr_q, waddr_d;
  logic [ASIZE-1:0] raddr_q, raddr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty, wacc, racc;

  // Flags come from the count register only, so no input reaches an output combinationally.
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign wacc  = bus.winc & ~full & ~rst;
  assign racc  = bus.rinc & ~empty & ~rst;

  always_comb begin
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~bus.clr_err;
    underflow_d = underflow_q & ~bus.clr_err;
    if (wacc) waddr_d = waddr_q + PTR_ONE;
    if (racc) raddr_d = raddr_q + PTR_ONE;
    case ({wacc, racc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A new error in the same cycle as clr_err keeps the flag set.
    if (bus.winc & full)  overflow_d  = 1'b1;
    if (bus.rinc & empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q     <= '0;
      raddr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wacc) mem_q[waddr_q] <= bus.wdata;
  end

`ifdef FIFO_FWFT_EN
  assign bus.rdata = mem_q[raddr_q];
`else
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (racc) rdata_q <= mem_q[raddr_q];
  end

  assign bus.rdata = rdata_q;
`endif

  assign bus.wfull         = full;
  assign bus.wfull_almost  = (count_q >= CNT_AF);
  assign bus.rempty        = empty;
  assign bus.rempty_almost = (count_q <= CNT_AE);
  assign bus.count         = count_q;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a default instance plus one with thresholds 5/2.
// Read checks follow the read mode selected by FIFO_FWFT_EN.
module tb_fifo_sync_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.DSIZE(12), .ASIZE(3)) a_if ();
  fifo_sync_param_if #(.DSIZE(12), .ASIZE(3)) b_if ();

  fifo_sync_param #(.DSIZE(12), .ASIZE(3)) u_dut (
    .clk(clk), .rst(rst), .bus(a_if)
  );

  fifo_sync_param #(.DSIZE(12), .ASIZE(3), .AFULL_TH(5), .AEMPTY_TH(2)) u_th (
    .clk(clk), .rst(rst), .bus(b_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_if.wdata = '0; a_if.winc = 1'b0; a_if.rinc = 1'b0; a_if.clr_err = 1'b0;
    b_if.wdata = '0; b_if.winc = 1'b0; b_if.rinc = 1'b0; b_if.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cnt++;
    if (a_if.count !== 4'd0) $display("FAIL reset_count got %0d want 0", a_if.count); else pass_cnt++;
    chk_cnt++;
    if ({a_if.rempty, a_if.rempty_almost, a_if.wfull, a_if.wfull_almost} !== 4'b1100)
      $display("FAIL reset_flags got %b want 1100",
               {a_if.rempty, a_if.rempty_almost, a_if.wfull, a_if.wfull_almost});
    else pass_cnt++;
    chk_cnt++;
    if ({a_if.overflow, a_if.underflow} !== 2'b00)
      $display("FAIL reset_err got %b want 00", {a_if.overflow, a_if.underflow}); else pass_cnt++;
`ifndef FIFO_FWFT_EN
    chk_cnt++;
    if (a_if.rdata !== 12'h000) $display("FAIL reset_rdata got %h want 000", a_if.rdata); else pass_cnt++;
`endif
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      a_if.wdata = 12'(i + 1); a_if.winc = 1'b1;
      step();
      chk_cnt++;
      if (a_if.count !== 4'(i + 1) || a_if.wfull !== (i == 7) || a_if.wfull_almost !== (i >= 6))
        $display("FAIL fill_%0d got cnt=%0d full=%b afull=%b want cnt=%0d full=%b afull=%b",
                 i, a_if.count, a_if.wfull, a_if.wfull_almost, i + 1, (i == 7), (i >= 6));
      else pass_cnt++;
    end
    a_if.winc = 1'b0;
    for (int i = 0; i < 8; i++) begin
`ifdef FIFO_FWFT_EN
      chk_cnt++;
      if (a_if.rdata !== 12'(i + 1)) $display("FAIL drain_%0d got %h want %h", i, a_if.rdata, 12'(i + 1));
      else pass_cnt++;
      a_if.rinc = 1'b1;
      step();
`else
      a_if.rinc = 1'b1;
      step();
      chk_cnt++;
      if (a_if.rdata !== 12'(i + 1)) $display("FAIL drain_%0d got %h want %h", i, a_if.rdata, 12'(i + 1));
      else pass_cnt++;
`endif
    end
    a_if.rinc = 1'b0;
    chk_cnt++;
    if (a_if.count !== 4'd0 || a_if.rempty !== 1'b1)
      $display("FAIL drain_end got cnt=%0d empty=%b want cnt=0 empty=1", a_if.count, a_if.rempty);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin
      a_if.wdata = 12'h101 + 12'(i); a_if.winc = 1'b1;
      step();
    end
    a_if.wdata = 12'hABC;
    step();
    a_if.winc = 1'b0;
    chk_cnt++;
    if (a_if.count !== 4'd8 || a_if.overflow !== 1'b1)
      $display("FAIL ovf_set got cnt=%0d ovf=%b want cnt=8 ovf=1", a_if.count, a_if.overflow);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (a_if.overflow !== 1'b1) $display("FAIL ovf_hold got %b want 1", a_if.overflow); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
`ifdef FIFO_FWFT_EN
      chk_cnt++;
      if (a_if.rdata !== 12'h101 + 12'(i))
        $display("FAIL ovf_drain_%0d got %h want %h", i, a_if.rdata, 12'h101 + 12'(i));
      else pass_cnt++;
      a_if.rinc = 1'b1;
      step();
`else
      a_if.rinc = 1'b1;
      step();
      chk_cnt++;
      if (a_if.rdata !== 12'h101 + 12'(i))
        $display("FAIL ovf_drain_%0d got %h want %h", i, a_if.rdata, 12'h101 + 12'(i));
      else pass_cnt++;
`endif
    end
    a_if.rinc = 1'b0;
    chk_cnt++;
    if (a_if.rempty !== 1'b1 || a_if.underflow !== 1'b0)
      $display("FAIL ovf_empty got empty=%b unf=%b want 1 0", a_if.rempty, a_if.underflow);
    else pass_cnt++;
    a_if.clr_err = 1'b1;
    step();
    a_if.clr_err = 1'b0;
    chk_cnt++;
    if (a_if.overflow !== 1'b0) $display("FAIL ovf_clr got %b want 0", a_if.overflow); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    a_if.wdata = 12'h055; a_if.winc = 1'b1; a_if.rinc = 1'b1;
    step();
    a_if.rinc = 1'b0;
    chk_cnt++;
    if (a_if.count !== 4'd1 || a_if.underflow !== 1'b1 || a_if.overflow !== 1'b0)
      $display("FAIL empty_rw got cnt=%0d unf=%b ovf=%b want 1 1 0", a_if.count, a_if.underflow, a_if.overflow);
    else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      a_if.wdata = 12'h056 + 12'(i);
      step();
    end
    chk_cnt++;
    if (a_if.wfull !== 1'b1) $display("FAIL rw_prefull got %b want 1", a_if.wfull); else pass_cnt++;
    a_if.wdata = 12'h0FF; a_if.rinc = 1'b1;
    step();
    a_if.winc = 1'b0; a_if.rinc = 1'b0;
    chk_cnt++;
    if (a_if.count !== 4'd7 || a_if.overflow !== 1'b1)
      $display("FAIL full_rw got cnt=%0d ovf=%b want 7 1", a_if.count, a_if.overflow);
    else pass_cnt++;
    chk_cnt++;
`ifdef FIFO_FWFT_EN
    if (a_if.rdata !== 12'h056) $display("FAIL full_rw_data got %h want 056", a_if.rdata); else pass_cnt++;
`else
    if (a_if.rdata !== 12'h055) $display("FAIL full_rw_data got %h want 055", a_if.rdata); else pass_cnt++;
`endif
    a_if.rinc = 1'b1;
    for (int i = 0; i < 7; i++) step();
    a_if.rinc = 1'b0;
    chk_cnt++;
`ifdef FIFO_FWFT_EN
    if (a_if.rempty !== 1'b1) $display("FAIL rw_drain got empty=%b want 1", a_if.rempty); else pass_cnt++;
`else
    if (a_if.rdata !== 12'h05C || a_if.rempty !== 1'b1)
      $display("FAIL rw_drain got %h empty=%b want 05c 1", a_if.rdata, a_if.rempty);
    else pass_cnt++;
`endif
    a_if.clr_err = 1'b1;
    step();
    a_if.clr_err = 1'b0;
  endtask

  task automatic test_wrap();
    a_if.winc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_if.wdata = 12'h200 + 12'(i);
      step();
    end
    a_if.rinc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_if.wdata = 12'h203 + 12'(i);
`ifdef FIFO_FWFT_EN
      chk_cnt++;
      if (a_if.rdata !== 12'h200 + 12'(i))
        $display("FAIL wrap_data_%0d got %h want %h", i, a_if.rdata, 12'h200 + 12'(i));
      else pass_cnt++;
      step();
`else
      step();
      chk_cnt++;
      if (a_if.rdata !== 12'h200 + 12'(i))
        $display("FAIL wrap_data_%0d got %h want %h", i, a_if.rdata, 12'h200 + 12'(i));
      else pass_cnt++;
`endif
      chk_cnt++;
      if (a_if.count !== 4'd3) $display("FAIL wrap_cnt_%0d got %0d want 3", i, a_if.count); else pass_cnt++;
    end
    a_if.winc = 1'b0;
    for (int i = 0; i < 3; i++) begin
`ifdef FIFO_FWFT_EN
      chk_cnt++;
      if (a_if.rdata !== 12'h214 + 12'(i))
        $display("FAIL wrap_tail_%0d got %h want %h", i, a_if.rdata, 12'h214 + 12'(i));
      else pass_cnt++;
      step();
`else
      step();
      chk_cnt++;
      if (a_if.rdata !== 12'h214 + 12'(i))
        $display("FAIL wrap_tail_%0d got %h want %h", i, a_if.rdata, 12'h214 + 12'(i));
      else pass_cnt++;
`endif
    end
    a_if.rinc = 1'b0;
    chk_cnt++;
    if (a_if.rempty !== 1'b1 || a_if.underflow !== 1'b0)
      $display("FAIL wrap_end got empty=%b unf=%b want 1 0", a_if.rempty, a_if.underflow);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    a_if.winc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_if.wdata = 12'h300 + 12'(i);
      step();
    end
    a_if.wdata = 12'h3FF; a_if.rinc = 1'b1; a_if.clr_err = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; a_if.winc = 1'b0; a_if.rinc = 1'b0;
    chk_cnt++;
    if (a_if.count !== 4'd0 || a_if.rempty !== 1'b1 || a_if.wfull_almost !== 1'b0)
      $display("FAIL rstmid_cnt got cnt=%0d empty=%b afull=%b want 0 1 0",
               a_if.count, a_if.rempty, a_if.wfull_almost);
    else pass_cnt++;
    chk_cnt++;
    if ({a_if.overflow, a_if.underflow} !== 2'b00)
      $display("FAIL rstmid_err got %b want 00", {a_if.overflow, a_if.underflow}); else pass_cnt++;
`ifndef FIFO_FWFT_EN
    chk_cnt++;
    if (a_if.rdata !== 12'h000) $display("FAIL rstmid_rdata got %h want 000", a_if.rdata); else pass_cnt++;
`endif
    a_if.wdata = 12'h321; a_if.winc = 1'b1;
    step();
    a_if.winc = 1'b0;
`ifdef FIFO_FWFT_EN
    chk_cnt++;
    if (a_if.rdata !== 12'h321) $display("FAIL rstmid_first got %h want 321", a_if.rdata); else pass_cnt++;
    a_if.rinc = 1'b1;
    step();
`else
    a_if.rinc = 1'b1;
    step();
    chk_cnt++;
    if (a_if.rdata !== 12'h321) $display("FAIL rstmid_first got %h want 321", a_if.rdata); else pass_cnt++;
`endif
    a_if.rinc = 1'b0;
    chk_cnt++;
    if (a_if.rempty !== 1'b1) $display("FAIL rstmid_empty got %b want 1", a_if.rempty); else pass_cnt++;
  endtask

  task automatic test_thresholds();
    chk_cnt++;
    if (b_if.rempty_almost !== 1'b1 || b_if.wfull_almost !== 1'b0)
      $display("FAIL th_init got ae=%b af=%b want 1 0", b_if.rempty_almost, b_if.wfull_almost);
    else pass_cnt++;
    b_if.winc = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      b_if.wdata = 12'h122 + 12'(k);
      step();
      if (k == 1) begin
        b_if.winc = 1'b0;
        step();
        chk_cnt++;
`ifdef FIFO_FWFT_EN
        if (b_if.rdata !== 12'h123) $display("FAIL th_fwft got %h want 123", b_if.rdata); else pass_cnt++;
`else
        if (b_if.rdata !== 12'h000) $display("FAIL th_noread got %h want 000", b_if.rdata); else pass_cnt++;
`endif
        b_if.winc = 1'b1;
      end
      chk_cnt++;
      if (b_if.wfull_almost !== (k >= 5) || b_if.rempty_almost !== (k <= 2))
        $display("FAIL th_fill_%0d got af=%b ae=%b want af=%b ae=%b",
                 k, b_if.wfull_almost, b_if.rempty_almost, (k >= 5), (k <= 2));
      else pass_cnt++;
    end
    b_if.winc = 1'b0;
    b_if.rinc = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      step();
      chk_cnt++;
      if (b_if.wfull_almost !== (k >= 5) || b_if.rempty_almost !== (k <= 2) || b_if.count !== 4'(k))
        $display("FAIL th_drain_%0d got af=%b ae=%b cnt=%0d want af=%b ae=%b cnt=%0d",
                 k, b_if.wfull_almost, b_if.rempty_almost, b_if.count, (k >= 5), (k <= 2), k);
      else pass_cnt++;
    end
    b_if.rinc = 1'b0;
`ifndef FIFO_FWFT_EN
    chk_cnt++;
    if (b_if.rdata !== 12'h12A) $display("FAIL th_last got %h want 12a", b_if.rdata); else pass_cnt++;
`endif
  endtask

  initial begin
    idle_inputs();
    step();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_thresholds();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Single-clock, parametrised FIFO: the next generation of the team's FIFO building block, for datapaths where producer and consumer share one clock. Depth and width are generic, thresholds for the almost-full and almost-empty flags are programmable, occupancy is exported, and sticky overflow/underflow error flags are provided. Read data is registered by default; a compile-time option selects first-word-fall-through (show-ahead) mode.

## Interface
- DSIZE, 12, data width in bits.
- ASIZE, 3, address width; depth = 2^ASIZE entries; legal ASIZE ≥ 1.
- AFULL_TH, 2^ASIZE−1, wfull_almost asserts when count ≥ AFULL_TH; legal 1..2^ASIZE.
- AEMPTY_TH, 1, rempty_almost asserts when count ≤ AEMPTY_TH; legal 0..2^ASIZE−1.

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wdata  in  DSIZE  write data.
- winc  in  1  write request.
- wfull  out  1  count == 2^ASIZE.
- wfull_almost  out  1  count ≥ AFULL_TH.
- rinc  in  1  read request.
- rdata  out  DSIZE  read data (see Operation).
- rempty  out  1  count == 0.
- rempty_almost  out  1  count ≤ AEMPTY_TH.
- count  out  ASIZE+1  current occupancy, 0..2^ASIZE.
- clr_err  in  1  clears overflow/underflow.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Storage: 2^ASIZE × DSIZE array; write pointer waddr and read pointer raddr, ASIZE bits each, wrap modulo 2^ASIZE naturally. Memory contents are not reset.
- Write accepted iff winc & !wfull (flag value before the edge): mem[waddr] ← wdata, waddr += 1.
- Read accepted iff rinc & !rempty: raddr += 1.
- count ← count + wacc − racc; simultaneous accepted read and write leave count unchanged.
- Full + winc + rinc: read accepted, write rejected, overflow set, count → 2^ASIZE−1.
- Empty + winc + rinc: write accepted, read rejected, underflow set, count → 1.
- All flags are decoded from the count register only; no combinational path from winc/rinc/wdata to any output.
- overflow/underflow: set on the offending cycle, held until rst or clr_err; clr_err on the same cycle as a new error leaves the flag set (set wins).
- Registered-read mode (default): on accepted read, rdata ← mem[raddr] at the same edge; rdata otherwise holds its value.
- rst: waddr, raddr, count, rdata, overflow, underflow ← 0; rempty=1, rempty_almost=1, wfull=0, wfull_almost=0 (for legal AFULL_TH). winc/rinc are ignored in the rst cycle. Reset mid-traffic discards all queued data.

## Timing
- Write at edge N: count, flags and (in FWFT) rdata reflect it after edge N.
- Registered mode: rinc sampled at edge N, data presented after edge N (read latency 1 cycle, same as the previous FIFO's output register).
- Write-to-read minimum: a word written at edge N is readable with rinc at edge N+1.
- Throughput: one write and one read per cycle sustained, at any occupancy 1..2^ASIZE−1.

## Configuration
- FIFO_FWFT_EN defined: rdata = mem[raddr] combinationally from the registered read pointer. The head word is valid whenever rempty=0, and rinc acts as a pop/acknowledge. rdata is undefined while empty; after rst it is mem[0].
- Not defined: registered-read mode as above; rdata reset to 0.

## Test plan
- Fill/drain (DSIZE=12, ASIZE=3): write 0x001..0x008 on 8 consecutive cycles -> wfull=1 and count=8 after the 8th edge, wfull_almost=1 from count=7. Then read 8 -> rdata sequence 0x001..0x008, rempty=1, count=0.
- Overflow: at full, winc=1 with wdata=0xABC -> count stays 8, overflow=1 held; the subsequent drain never returns 0xABC; clr_err=1 -> overflow=0 next cycle.
- Underflow plus simultaneous access: empty, winc=rinc=1 with wdata=0x055 -> count=1, underflow=1. Full, winc=rinc=1 -> count=7, overflow=1.
- Wrap-around: 20 cycles of continuous write+read at count=3 with an incrementing pattern -> output is in order with no loss, count constant at 3, pointers wrap twice.
- Reset mid-operation: count=5, assert rst for one cycle with winc=1 -> count=0, rempty=1, rdata=0, flags cleared, no write recorded.
- Thresholds: AFULL_TH=5, AEMPTY_TH=2 -> wfull_almost first high at count=5; rempty_almost low from count=3. Repeat with FIFO_FWFT_EN: the first write of 0x123 shows rdata=0x123 one cycle later without rinc.
